// File: rtl/vram_pkg.sv
// Shared types and text-mode geometry for the VRAM arbiter and its tag pipeline.
package vram_pkg;

    localparam int CHARS_PER_WORD = 4;
    localparam int TEXT_COLS      = 80;
    localparam int TEXT_ROWS      = 30;
    localparam int VRAM_WORDS     = (TEXT_COLS * TEXT_ROWS) / CHARS_PER_WORD;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_WAIT = 2'd1,
        CPU_READ = 2'd2
    } cpu_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/vram_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register; pop_o lines up with the BRAM
// read data produced for the grant that pushed it.
module vram_tag_pipe
    import vram_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  tag_t push_i,
    output tag_t pop_o
);

    tag_t tag_q [RD_LAT];
    tag_t tag_d [RD_LAT];

    always_comb begin
        tag_d[0] = push_i;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign pop_o = tag_q[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display has fixed priority, the CPU gets a forced
// slot after MAX_WAIT consecutive losses; read data is routed back by tag.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_rvalid,
    output logic [DATA_W-1:0]     disp_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_be,
    output logic                  cpu_ack,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [15:0]           disp_miss_cnt
);

    localparam int WAIT_W = 8;

    cpu_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [15:0]       miss_q, miss_d;

    logic cpu_compete, force_cpu, cpu_win, disp_win;
    tag_t push_tag, pop_tag;

    // CPU handshake: req/we/addr/wdata/be are held until the one-cycle
    // cpu_ack; the ack cycle itself never starts a new CPU access, so a
    // requester that drops req on seeing ack cannot cause a repeat.
    always_comb begin
        cpu_compete = !reset && !cpu_ack_q && cpu_req &&
                      (state_q == CPU_IDLE || state_q == CPU_WAIT);
        force_cpu   = cpu_compete && (wait_q == WAIT_W'(MAX_WAIT));
        disp_win    = !reset && disp_req && !force_cpu;
        cpu_win     = cpu_compete && !disp_win;
    end

    assign disp_gnt  = disp_win;
    assign mem_en    = cpu_win || disp_win;
    assign mem_we    = (cpu_win && cpu_we) ? cpu_be : '0;
    assign mem_addr  = cpu_win ? cpu_addr : (disp_win ? disp_addr : '0);
    assign mem_wdata = mem_en ? cpu_wdata : '0;

    always_comb begin
        push_tag.valid = disp_win || (cpu_win && !cpu_we);
        push_tag.owner = cpu_win ? OWN_CPU : OWN_DISP;
    end

    vram_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .push_i (push_tag),
        .pop_o  (pop_tag)
    );

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        cpu_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        disp_rvalid_d = 1'b0;
        disp_rdata_d  = disp_rdata_q;
        miss_d        = miss_q;

        case (state_q)
            CPU_IDLE, CPU_WAIT: begin
                if (cpu_compete) begin
                    if (cpu_win) begin
                        state_d = cpu_we ? CPU_IDLE : CPU_READ;
                    end else begin
                        state_d = CPU_WAIT;
                    end
                end
            end
            CPU_READ: begin
                if (pop_tag.valid && pop_tag.owner == OWN_CPU) begin
                    state_d     = CPU_IDLE;
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = mem_rdata;
                end
            end
            default: state_d = CPU_IDLE;
        endcase

        if (cpu_win && cpu_we) begin
            cpu_ack_d = 1'b1;
        end

        if (cpu_win) begin
            wait_d = '0;
        end else if (cpu_compete) begin
            if (wait_q < WAIT_W'(MAX_WAIT)) begin
                wait_d = wait_q + 1'b1;
            end
        end else if (state_q == CPU_IDLE && !cpu_req) begin
            wait_d = '0;
        end

        if (pop_tag.valid && pop_tag.owner == OWN_DISP) begin
            disp_rvalid_d = 1'b1;
            disp_rdata_d  = mem_rdata;
        end

        if (force_cpu && disp_req && miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CPU_IDLE;
            wait_q        <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            disp_rvalid_q <= disp_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            miss_q        <= miss_d;
        end
    end

    assign cpu_ack       = cpu_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign disp_rvalid   = disp_rvalid_q;
    assign disp_rdata    = disp_rdata_q;
    assign disp_miss_cnt = miss_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural BRAM, shadow memory reference and
// per-scenario tasks with inline comparisons.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int BW       = DW / 8;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [BW-1:0] cpu_be = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   disp_miss_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_miss = 0;
    logic fill = 1'b1;
    logic [31:0] seed = 32'h0;
    logic [DW-1:0] ref_mem [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .disp_miss_cnt(disp_miss_cnt)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 32'h9E3779B1) ^ seed;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural BRAM with RD_LAT-cycle registered read path
    logic [DW-1:0] bram [1024];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) bram[i] <= init_word(i);
        end else if (mem_en) begin
            bram[mem_addr] <= merge(bram[mem_addr], mem_wdata, mem_we);
        end
        rd_pipe[0] <= bram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [BW-1:0] be,
                              output logic [DW-1:0] rd, output int scyc,
                              output int gcyc, output int acyc,
                              output logic [BW-1:0] we_g, output logic [AW-1:0] addr_g,
                              output logic [DW-1:0] wd_g, output int dgnt_n);
        rd = '0; gcyc = -1; acyc = -100; we_g = '0; addr_g = '0; wd_g = '0; dgnt_n = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
        scyc = cyc;
        for (int i = 0; i < 80 && acyc < 0; i++) begin
            #1;
            if (gcyc < 0) begin
                if (disp_gnt) dgnt_n++;
                else if (mem_en) begin
                    gcyc = cyc; we_g = mem_we; addr_g = mem_addr; wd_g = mem_wdata;
                end
            end
            @(negedge clk);
            if (cpu_ack) begin
                acyc = cyc; rd = cpu_rdata;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; disp_req = 1'b1; disp_addr = 10'd3;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd7; cpu_wdata = '1; cpu_be = '1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_we !== '0) begin
                failures++; $display("FAIL reset_mem_we: got %h expected 0", mem_we);
            end
            if (i > 0) begin
                checks++;
                if ({cpu_ack, disp_rvalid, cpu_rdata, disp_rdata, disp_miss_cnt} !== '0) begin
                    failures++;
                    $display("FAIL reset_regs: ack=%b rvalid=%b crd=%h drd=%h miss=%0d expected all 0",
                             cpu_ack, disp_rvalid, cpu_rdata, disp_rdata, disp_miss_cnt);
                end
            end
            @(negedge clk);
            fill = 1'b0;
        end
        reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        checks++;
        if ({cpu_ack, disp_rvalid, mem_en, disp_gnt, disp_miss_cnt} !== '0) begin
            failures++;
            $display("FAIL post_reset: ack=%b rvalid=%b en=%b gnt=%b miss=%0d expected all 0",
                     cpu_ack, disp_rvalid, mem_en, disp_gnt, disp_miss_cnt);
        end
        exp_miss = 0;
    endtask

    task automatic test_cpu_write_read();
        logic [DW-1:0] rd, wdg; logic [BW-1:0] weg; logic [AW-1:0] ag;
        int s, g, a, dn;
        cpu_access(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, rd, s, g, a, weg, ag, wdg, dn);
        ref_mem[5] = merge(ref_mem[5], 32'hDEADBEEF, 4'hF);
        checks++;
        if (g !== s || weg !== 4'hF || ag !== 10'd5 || wdg !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_grant: gcyc=%0d scyc=%0d we=%h addr=%0d wd=%h expected immediate F/5/deadbeef",
                     g, s, weg, ag, wdg);
        end
        checks++;
        if (a - g !== 1) begin
            failures++; $display("FAIL wr_latency: got %0d expected 1", a - g);
        end
        cpu_access(1'b0, 10'd5, '0, '0, rd, s, g, a, weg, ag, wdg, dn);
        checks++;
        if (a - g !== RD_LAT + 1 || weg !== '0) begin
            failures++; $display("FAIL rd_latency: got %0d (we=%h) expected %0d", a - g, weg, RD_LAT + 1);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || rd !== ref_mem[5]) begin
            failures++; $display("FAIL rd_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] rd, wdg; logic [BW-1:0] weg; logic [AW-1:0] ag, addr;
        int s, g, a, dn;
        addr = AW'($urandom_range(100, VRAM_WORDS - 1));
        cpu_access(1'b1, addr, 32'h11223344, 4'hF, rd, s, g, a, weg, ag, wdg, dn);
        ref_mem[addr] = merge(ref_mem[addr], 32'h11223344, 4'hF);
        cpu_access(1'b1, addr, 32'h0000AB00, 4'b0010, rd, s, g, a, weg, ag, wdg, dn);
        ref_mem[addr] = merge(ref_mem[addr], 32'h0000AB00, 4'b0010);
        checks++;
        if (weg !== 4'b0010 || ag !== addr) begin
            failures++; $display("FAIL be_mem_we: got %b@%0d expected 0010@%0d", weg, ag, addr);
        end
        cpu_access(1'b0, addr, '0, '0, rd, s, g, a, weg, ag, wdg, dn);
        checks++;
        if (rd !== 32'h1122AB44 || rd !== ref_mem[addr]) begin
            failures++; $display("FAIL be_readback: got %h expected 1122ab44", rd);
        end
    endtask

    task automatic test_disp_stream(input int n, input bit rnd);
        logic [DW-1:0] exp_q[$];
        int due_q[$];
        int seen = 0;
        int issued = 0;
        for (int i = 0; i < n + 8; i++) begin
            @(negedge clk);
            if (i < n) begin
                disp_req  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                disp_addr = rnd ? AW'($urandom_range(0, VRAM_WORDS - 1)) : AW'(i);
            end else begin
                disp_req = 1'b0;
            end
            #1;
            // With the CPU idle every display request is accepted that cycle
            checks++;
            if (disp_gnt !== disp_req || (disp_req && (mem_addr !== disp_addr || mem_we !== '0))) begin
                failures++;
                $display("FAIL disp_gnt: gnt=%b addr=%0d we=%h expected gnt=%b addr=%0d we=0",
                         disp_gnt, mem_addr, mem_we, disp_req, disp_addr);
            end
            if (disp_req) begin
                exp_q.push_back(ref_mem[disp_addr]);
                due_q.push_back(cyc + RD_LAT + 1);
                issued++;
            end
            checks++;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                if (disp_rvalid !== 1'b1 || disp_rdata !== exp_q[0]) begin
                    failures++;
                    $display("FAIL disp_rdata: rvalid=%b data=%h expected 1/%h at cyc %0d",
                             disp_rvalid, disp_rdata, exp_q[0], cyc);
                end
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
                seen++;
            end else if (disp_rvalid !== 1'b0) begin
                failures++; $display("FAIL disp_rvalid_extra: got 1 expected 0 at cyc %0d", cyc);
            end
        end
        checks++;
        if (seen != issued) begin
            failures++; $display("FAIL disp_count: got %0d expected %0d", seen, issued);
        end
    endtask

    task automatic test_starvation();
        logic [DW-1:0] rd, wdg; logic [BW-1:0] weg; logic [AW-1:0] ag;
        int s, g, a, dn;
        disp_req = 1'b1; disp_addr = AW'($urandom_range(0, VRAM_WORDS - 1));
        cpu_access(1'b0, 10'd9, '0, '0, rd, s, g, a, weg, ag, wdg, dn);
        disp_req = 1'b0;
        exp_miss++;
        checks++;
        if (dn !== MAX_WAIT || g - s !== MAX_WAIT) begin
            failures++; $display("FAIL starve_losses: got %0d/%0d expected %0d", dn, g - s, MAX_WAIT);
        end
        checks++;
        if (a - g !== RD_LAT + 1 || rd !== ref_mem[9]) begin
            failures++; $display("FAIL starve_read: lat=%0d data=%h expected %0d/%h", a - g, rd, RD_LAT + 1, ref_mem[9]);
        end
        #1;
        checks++;
        if (disp_miss_cnt !== 16'(exp_miss)) begin
            failures++; $display("FAIL starve_miss: got %0d expected %0d", disp_miss_cnt, exp_miss);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] rd, wdg; logic [BW-1:0] weg; logic [AW-1:0] ag;
        int s, g, a, dn;
        int stray = 0;
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 10'd17;
        @(negedge clk);
        disp_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd21;
        #1;
        checks++;
        if (mem_en !== 1'b1 || disp_gnt !== 1'b0 || mem_addr !== 10'd21) begin
            failures++; $display("FAIL midrst_grant: en=%b gnt=%b addr=%0d expected 1/0/21", mem_en, disp_gnt, mem_addr);
        end
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0;
        exp_miss = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (cpu_ack !== 1'b0 || disp_rvalid !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL midrst_stray: got %0d pulses expected 0", stray);
        end
        checks++;
        if (disp_miss_cnt !== 16'(exp_miss)) begin
            failures++; $display("FAIL midrst_miss: got %0d expected %0d", disp_miss_cnt, exp_miss);
        end
        cpu_access(1'b0, 10'd21, '0, '0, rd, s, g, a, weg, ag, wdg, dn);
        checks++;
        if (a - g !== RD_LAT + 1 || rd !== ref_mem[21]) begin
            failures++; $display("FAIL midrst_fresh: lat=%0d data=%h expected %0d/%h", a - g, rd, RD_LAT + 1, ref_mem[21]);
        end
    endtask

    task automatic test_random_cpu(input int n);
        logic [DW-1:0] rd, wdg, wd; logic [BW-1:0] weg, be; logic [AW-1:0] ag, addr;
        logic we, hold;
        int s, g, a, dn;
        for (int k = 0; k < n; k++) begin
            hold = ($urandom_range(0, 3) == 0);
            we   = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(40, 55));
            be   = BW'($urandom_range(1, 15));
            wd   = $urandom;
            disp_req = hold; disp_addr = AW'($urandom_range(0, VRAM_WORDS - 1));
            cpu_access(we, addr, wd, be, rd, s, g, a, weg, ag, wdg, dn);
            disp_req = 1'b0;
            if (hold) exp_miss++;
            checks++;
            if (g - s !== (hold ? MAX_WAIT : 0)) begin
                failures++; $display("FAIL rnd_wait: got %0d expected %0d", g - s, hold ? MAX_WAIT : 0);
            end
            if (we) begin
                ref_mem[addr] = merge(ref_mem[addr], wd, be);
                checks++;
                if (weg !== be || ag !== addr || wdg !== wd || a - g !== 1) begin
                    failures++;
                    $display("FAIL rnd_write: we=%h addr=%0d wd=%h lat=%0d expected %h/%0d/%h/1",
                             weg, ag, wdg, a - g, be, addr, wd);
                end
            end else begin
                checks++;
                if (rd !== ref_mem[addr] || a - g !== RD_LAT + 1) begin
                    failures++;
                    $display("FAIL rnd_read: data=%h lat=%0d expected %h/%0d", rd, a - g, ref_mem[addr], RD_LAT + 1);
                end
            end
            #1;
            checks++;
            if (disp_miss_cnt !== 16'(exp_miss)) begin
                failures++; $display("FAIL rnd_miss: got %0d expected %0d", disp_miss_cnt, exp_miss);
            end
        end
    endtask

    initial begin
        seed = $urandom;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_cpu_write_read();
        test_byte_enable();
        test_disp_stream(40, 1'b0);
        test_starvation();
        test_reset_mid_read();
        test_disp_stream(60, 1'b1);
        test_random_cpu(24);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port text-mode VRAM BRAM between two requesters: the display fetch engine (character/attribute prefetch for the HDMI text controller) and the MicroBlaze AXI slave front end.
- Display has fixed priority. A starvation guard forces a CPU slot after MAX_WAIT consecutive losses.
- Routes read data back to the correct requester through a latency-matched tag pipeline.
- Sits between the AXI register/VRAM interface, the display fetch pipeline and the BRAM primitive.

Parameters:
ADDR_W, 10, VRAM word address width (600 words used for 80x30 chars, 4 chars/word)
DATA_W, 32, VRAM word width; must be a multiple of 8
RD_LAT, 2, BRAM read latency in cycles from mem_en to valid mem_rdata (1..4)
MAX_WAIT, 15, consecutive cycles the CPU may lose before it is forced a slot (1..255)

Ports:
clk  in  1  system clock (single domain)
reset  in  1  synchronous, active-high reset
disp_req  in  1  display read request for this cycle
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display request accepted this cycle (combinational)
disp_rvalid  out  1  display read data valid pulse
disp_rdata  out  DATA_W  display read data
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_be  in  DATA_W/8  CPU byte enables for writes
cpu_ack  out  1  one-cycle completion pulse; cpu_rdata is valid with it for reads
cpu_rdata  out  DATA_W  CPU read data, registered
mem_en  out  1  BRAM enable (combinational from winner)
mem_we  out  DATA_W/8  BRAM byte write enables
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data
disp_miss_cnt  out  16  saturating count of display requests denied by the starvation guard

Behaviour:
- Reset is synchronous and applies on the cycle reset is sampled high. All registered outputs go to 0: cpu_ack, cpu_rdata, disp_rvalid, disp_rdata, disp_miss_cnt. FSM goes to CPU_IDLE, wait_cnt to 0, tag pipeline to empty.
- CPU FSM states:
  - CPU_IDLE: on cpu_req, the CPU competes for the port.
    - Granted + write: cpu_ack pulses next cycle; stay in or return to CPU_IDLE.
    - Granted + read: go to CPU_READ.
    - Not granted: go to CPU_WAIT.
  - CPU_WAIT: competes every cycle. On grant, go to CPU_IDLE (write) or CPU_READ (read).
  - CPU_READ: no new CPU grant is allowed. When the CPU tag leaves the pipeline, register mem_rdata into cpu_rdata, pulse cpu_ack, and go to CPU_IDLE.
- CPU protocol rules:
  - CPU must hold req/we/addr/wdata/be stable until cpu_ack.
  - cpu_req may be asserted again in the cycle after cpu_ack.
  - Write latency is grant + 1. Read latency is grant + RD_LAT + 1.
- Arbitration, decided each cycle:
  - CPU is competing when the FSM is in CPU_IDLE or CPU_WAIT and cpu_req = 1.
  - force_cpu = (wait_cnt == MAX_WAIT) and CPU is competing.
  - If force_cpu: CPU wins, disp_gnt = 0, and if disp_req = 1, disp_miss_cnt increments, saturating at 0xFFFF.
  - Else if disp_req: display wins, disp_gnt = 1.
  - Else if CPU is competing: CPU wins.
  - Else: mem_en = 0.
- wait_cnt:
  - Increments each cycle the CPU is competing and loses.
  - Clears on CPU grant and in CPU_IDLE with no request.
  - Never exceeds MAX_WAIT.
- Memory drive:
  - mem_en = 1 for the winner.
  - mem_we = cpu_be only for a CPU write grant; otherwise 0.
  - mem_wdata = cpu_wdata; mem_addr = winner's address.
  - Outputs are don't-care when mem_en = 0, but are driven to 0.
- Tag pipeline:
  - RD_LAT-stage shift register of {valid, owner}. Pushed on every read grant; writes push an invalid tag.
  - At the output stage, an owner=DISP tag registers mem_rdata into disp_rdata and pulses disp_rvalid. Display read latency is grant + RD_LAT + 1 cycles.
  - Display requests are back-to-back capable: one per cycle, in order.
- Reset mid-operation: in-flight tags are discarded; no cpu_ack or disp_rvalid is emitted for them.
- cpu_req dropped without ack is a protocol violation; behaviour is unspecified beyond FSM recovery at the next reset.

Decomposition:
- Package vram_pkg:
  - owner_e enum (OWN_DISP, OWN_CPU)
  - cpu_state_e (CPU_IDLE, CPU_WAIT, CPU_READ)
  - shared VRAM geometry constants (chars per word, 80x30 text size, VRAM_WORDS = 600)
- One sub-module: vram_tag_pipe, the parameterised RD_LAT-deep {valid, owner} shift register.

Test Plan:
- Reset: hold reset 3 cycles with both reqs high -> all outputs 0, no mem_we, disp_miss_cnt = 0.
- CPU write 0xDEADBEEF, be = 4'b1111, addr 5, disp idle -> mem_we = 4'hF with addr 5 in the grant cycle, cpu_ack next cycle. Then CPU read addr 5 -> cpu_ack after RD_LAT+1 = 3 cycles with cpu_rdata = 0xDEADBEEF.
- Display continuous reads addr 0..39 -> 40 disp_rvalid pulses in order, each 3 cycles after its grant, data matching the BRAM model.
- disp_req held high, CPU read pending -> CPU loses exactly 15 cycles, wins on the 16th, disp_gnt = 0 that cycle, disp_miss_cnt = 1, cpu_ack with correct data.
- Byte-enable write be = 4'b0010, wdata 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
- Reset asserted the cycle after a CPU read grant -> no cpu_ack ever for it. A fresh read after reset completes normally.
